// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared constants, encodings and classifier for tone detection and generation
package tone_pkg;

  localparam int unsigned CNT_W = 21;

  localparam logic [CNT_W-1:0] TIMEOUT   = 21'd1_300_000;
  localparam logic [CNT_W-1:0] WIN392_LO = 21'd312_500;
  localparam logic [CNT_W-1:0] WIN392_HI = 21'd325_250;
  localparam logic [CNT_W-1:0] WIN110_LO = 21'd1_113_600;
  localparam logic [CNT_W-1:0] WIN110_HI = 21'd1_159_100;
  localparam logic [1:0]       CONFIRM_CNT = 2'd3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_392  = 2'd1,
    CLS_110  = 2'd2
  } tone_class_e;

  // Windows are inclusive on both ends.
  function automatic tone_class_e classify(
    input logic [CNT_W-1:0] p,
    input logic [CNT_W-1:0] lo392,
    input logic [CNT_W-1:0] hi392,
    input logic [CNT_W-1:0] lo110,
    input logic [CNT_W-1:0] hi110
  );
    tone_class_e c;
    c = CLS_NONE;
    if (p >= lo392 && p <= hi392) begin
      c = CLS_392;
    end else if (p >= lo110 && p <= hi110) begin
      c = CLS_110;
    end
    return c;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with registered rising-edge pulse
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic edge_out
);

  logic meta_q, sync_q, prev_q, edge_q;
  logic meta_d, sync_d, prev_d, edge_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
    prev_d = sync_q;
    edge_d = sync_q & ~prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      edge_q <= edge_d;
    end
  end

  assign edge_out = edge_q;

endmodule

// File: rtl/tone_detect.sv
// rtl/tone_detect.sv - period measurement and 392 Hz / 110 Hz tone confirmation
module tone_detect
  import tone_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT_CYC   = TIMEOUT,
  parameter logic [CNT_W-1:0] WIN392_LO_CYC = WIN392_LO,
  parameter logic [CNT_W-1:0] WIN392_HI_CYC = WIN392_HI,
  parameter logic [CNT_W-1:0] WIN110_LO_CYC = WIN110_LO,
  parameter logic [CNT_W-1:0] WIN110_HI_CYC = WIN110_HI
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tone_in,
  output logic             det392,
  output logic             det110,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout
);

  logic edge_pulse;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pv_q, pv_d;
  logic             to_q, to_d;
  logic [1:0]       run_q, run_d;
  tone_class_e      cls_q, cls_d;
  tone_class_e      meas_cls;
  logic             det392_q, det392_d;
  logic             det110_q, det110_d;
  logic             at_timeout;

  sync_edge u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .d_in     (tone_in),
    .edge_out (edge_pulse)
  );

  // Timeout outranks a coincident edge; that edge is simply lost.
  assign at_timeout = (state_q == ST_MEASURE) && (cnt_q == TIMEOUT_CYC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (edge_pulse) state_d = ST_MEASURE;
        ST_MEASURE: if (at_timeout) state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    det392       = det392_q;
    det110       = det110_q;
    period       = period_q;
    period_valid = pv_q;
    timeout      = to_q;
  end

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    pv_d     = 1'b0;
    to_d     = 1'b0;
    if (!en) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = edge_pulse ? 21'd1 : 21'd0;
        end
        ST_MEASURE: begin
          if (at_timeout) begin
            cnt_d = '0;
            to_d  = 1'b1;
          end else if (edge_pulse) begin
            period_d = cnt_q;
            pv_d     = 1'b1;
            cnt_d    = 21'd1;
          end else begin
            cnt_d = cnt_q + 21'd1;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  assign meas_cls = classify(period_q, WIN392_LO_CYC, WIN392_HI_CYC,
                             WIN110_LO_CYC, WIN110_HI_CYC);

  // Classification runs on the registered period, one cycle behind period_valid.
  always_comb begin
    run_d = run_q;
    cls_d = cls_q;
    if (!en || at_timeout) begin
      run_d = 2'd0;
      cls_d = CLS_NONE;
    end else if (pv_q) begin
      if (meas_cls == CLS_NONE) begin
        run_d = 2'd0;
        cls_d = CLS_NONE;
      end else if (meas_cls == cls_q) begin
        run_d = (run_q == CONFIRM_CNT) ? run_q : run_q + 2'd1;
      end else begin
        run_d = 2'd1;
        cls_d = meas_cls;
      end
    end
    det392_d = (run_d == CONFIRM_CNT) && (cls_d == CLS_392);
    det110_d = (run_d == CONFIRM_CNT) && (cls_d == CLS_110);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      to_q     <= 1'b0;
      run_q    <= 2'd0;
      cls_q    <= CLS_NONE;
      det392_q <= 1'b0;
      det110_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      to_q     <= to_d;
      run_q    <= run_d;
      cls_q    <= cls_d;
      det392_q <= det392_d;
      det110_q <= det110_d;
    end
  end

endmodule
